// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: one instruction at a time through IDLE -> EXEC -> MEM -> WB.
// Define CPU_ERR_EN to get the sticky error flag and out-of-range address checks.
module multicycle_cpu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int NUM_REGS   = 4,
    localparam int RB          = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = 4 + 3*RB + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   done,
    output logic                   zero,
    output logic                   carry,
    output logic                   err,
    input  logic [RB-1:0]          dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_OR  = 4'd4, OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_ADDI = 4'd8, OP_LW = 4'd9, OP_SW = 4'd10, OP_LI = 4'd11;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t                   state_q, state_d;
    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [DATA_WIDTH-1:0]    rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    mem_q [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0]    alu_q, wdata_q;
    logic [ADDR_BITS-1:0]     addr_q;
    logic                     oor_q, zero_q, carry_q, err_q, done_q, done_d;

    logic [3:0]               op;
    logic [RB-1:0]            rd, rs, rt;
    logic [DATA_WIDTH-1:0]    imm, a, b, res;
    logic [DATA_WIDTH:0]      add_rt, sub_rt, add_imm;
    logic                     cout, illegal, is_mem, oor, err_set;

    assign op  = instr_q[INSTR_WIDTH-1 -: 4];
    assign rd  = instr_q[DATA_WIDTH+3*RB-1 -: RB];
    assign rs  = instr_q[DATA_WIDTH+2*RB-1 -: RB];
    assign rt  = instr_q[DATA_WIDTH+RB-1 -: RB];
    assign imm = instr_q[DATA_WIDTH-1:0];

    assign a       = rf_q[rs];
    assign b       = rf_q[rt];
    assign add_rt  = {1'b0, a} + {1'b0, b};
    assign sub_rt  = {1'b0, a} - {1'b0, b};
    assign add_imm = {1'b0, a} + {1'b0, imm};
    assign illegal = (op > OP_LI);
    assign is_mem  = (op == OP_LW) || (op == OP_SW);

`ifdef CPU_ERR_EN
    assign oor     = (add_imm[DATA_WIDTH-1:0] >> ADDR_BITS) != '0;
    assign err_set = illegal || (is_mem && oor);
`else
    assign oor     = 1'b0;
    assign err_set = 1'b0;
`endif

    always_comb begin
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, res} = add_rt;
            OP_SUB:  {cout, res} = sub_rt;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SHL:  res = a << b[2:0];
            OP_SHR:  res = a >> b[2:0];
            OP_ADDI: {cout, res} = add_imm;
            OP_LI:   res = imm;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (instr_valid) state_d = EXEC;
            EXEC: begin
                if (is_mem)                            state_d = MEM;
                else if (op == OP_NOP || illegal)      begin state_d = IDLE; done_d = 1'b1; end
                else                                   state_d = WB;
            end
            MEM: begin
                state_d = (op == OP_LW) ? WB : IDLE;
                done_d  = (op == OP_SW);
            end
            WB: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            case (state_q)
                IDLE: if (instr_valid) instr_q <= instruction;
                EXEC: begin
                    alu_q   <= res;
                    wdata_q <= b;
                    addr_q  <= add_imm[ADDR_BITS-1:0];
                    oor_q   <= oor;
                    if (op >= OP_ADD && op <= OP_ADDI) zero_q <= (res == '0);
                    if (op == OP_ADD || op == OP_SUB || op == OP_ADDI) carry_q <= cout;
                    if (err_set) err_q <= 1'b1;
                end
                // Out-of-range loads return 0; oor_q is never set without CPU_ERR_EN.
                MEM:  if (op == OP_LW) alu_q <= oor_q ? '0 : mem_q[addr_q];
                WB:   rf_q[rd] <= alu_q;
                default: ;
            endcase
        end
    end

    // Memory contents survive reset; a reset during MEM suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && state_q == MEM && op == OP_SW && !oor_q)
            mem_q[addr_q] <= wdata_q;
    end

    assign instr_ready = (state_q == IDLE);
    assign done        = done_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign err         = err_q;
    assign dbg_data    = rf_q[dbg_sel];
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu at default parameters (8-bit data, 32-word memory, 4 regs).
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] instruction;
    logic        instr_valid;
    logic        instr_ready, done, zero, carry, err;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int lat;
    int snap;

    multicycle_cpu dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .zero(zero), .carry(carry), .err(err),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt,
                                       input logic [7:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] r, input logic [7:0] exp);
        dbg_sel = r;
        #1;
        chk($sformatf("r%0d", r), {24'd0, dbg_data}, {24'd0, exp});
    endtask

    // Presents an instruction with valid held until done is seen; lat counts
    // negedges from the accept edge to the one where done is high.
    task automatic exec(input logic [17:0] ins, output int l);
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        l = 0;
        while (l < 20) begin
            @(negedge clk);
            l++;
            if (done === 1'b1) break;
        end
        instr_valid = 1'b0;
        if (l >= 20) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; instruction = '0; instr_valid = 1'b0; dbg_sel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_zero",  {31'd0, zero},  32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        for (int i = 0; i < 4; i++) chk_reg(i[1:0], 8'h00);

        // LI, LI, ADD with carry out
        exec(mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h05), lat); chk("li1_lat", lat, 3);
        exec(mk(4'd11, 2'd2, 2'd0, 2'd0, 8'hFC), lat); chk("li2_lat", lat, 3);
        exec(mk(4'd1, 2'd3, 2'd1, 2'd2, 8'h00), lat);  chk("add_lat", lat, 3);
        chk("ready_after", {31'd0, instr_ready}, 32'd1);
        chk_reg(2'd3, 8'h01);
        chk("add_carry", {31'd0, carry}, 32'd1);
        chk("add_zero",  {31'd0, zero},  32'd0);
        chk("done_cnt3", done_cnt, 3);

        // SUB to zero, SHL by rt[2:0]
        exec(mk(4'd2, 2'd0, 2'd1, 2'd1, 8'h00), lat);
        chk_reg(2'd0, 8'h00);
        chk("sub_zero",  {31'd0, zero},  32'd1);
        chk("sub_carry", {31'd0, carry}, 32'd0);
        exec(mk(4'd6, 2'd0, 2'd1, 2'd2, 8'h00), lat);
        chk_reg(2'd0, 8'h50);
        chk("shl_zero", {31'd0, zero}, 32'd0);
        exec(mk(4'd7, 2'd3, 2'd0, 2'd2, 8'h00), lat);
        chk_reg(2'd3, 8'h05);
        exec(mk(4'd11, 2'd3, 2'd0, 2'd0, 8'h01), lat);

        // SW then LW through address 0x08; check ready drops and single accept
        exec(mk(4'd10, 2'd0, 2'd1, 2'd3, 8'h03), lat); chk("sw_lat", lat, 3);
        @(negedge clk);
        instruction = mk(4'd9, 2'd2, 2'd1, 2'd0, 8'h03);
        instr_valid = 1'b1;
        snap = done_cnt;
        @(posedge clk);
        @(negedge clk);
        chk("busy_ready", {31'd0, instr_ready}, 32'd0);
        lat = 1;
        while (lat < 20 && done !== 1'b1) begin @(negedge clk); lat++; end
        instr_valid = 1'b0;
        chk("lw_lat", lat, 4);
        repeat (4) @(negedge clk);
        chk("lw_one_done", done_cnt - snap, 1);
        chk_reg(2'd2, 8'h01);

        // ADDI wrapping to zero sets carry and zero; NOP retires in 2
        exec(mk(4'd8, 2'd3, 2'd2, 2'd0, 8'hFF), lat);
        chk_reg(2'd3, 8'h00);
        chk("addi_carry", {31'd0, carry}, 32'd1);
        chk("addi_zero",  {31'd0, zero},  32'd1);
        exec(mk(4'd0, 2'd3, 2'd0, 2'd0, 8'h77), lat); chk("nop_lat", lat, 2);
        chk_reg(2'd3, 8'h00);

        // Reset during MEM of SW to 0x08 (r0=0x50 would overwrite 0x01)
        @(negedge clk);
        instruction = mk(4'd10, 2'd0, 2'd1, 2'd0, 8'h03);
        instr_valid = 1'b1;
        snap = done_cnt;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_done", done_cnt - snap, 0);
        chk("rst_mid_carry", {31'd0, carry}, 32'd0);
        for (int i = 0; i < 4; i++) chk_reg(i[1:0], 8'h00);
        exec(mk(4'd9, 2'd2, 2'd0, 2'd0, 8'h08), lat);
        chk_reg(2'd2, 8'h01);

`ifdef CPU_ERR_EN
        exec(mk(4'd14, 2'd2, 2'd0, 2'd0, 8'h33), lat); chk("ill_lat", lat, 2);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk_reg(2'd2, 8'h01);
        exec(mk(4'd11, 2'd1, 2'd0, 2'd0, 8'hFF), lat);
        exec(mk(4'd9, 2'd3, 2'd1, 2'd0, 8'h01), lat);
        exec(mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h40), lat);
        exec(mk(4'd9, 2'd2, 2'd1, 2'd0, 8'h00), lat);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk_reg(2'd2, 8'h00);
`else
        exec(mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h40), lat);
        exec(mk(4'd11, 2'd3, 2'd0, 2'd0, 8'hA5), lat);
        exec(mk(4'd10, 2'd0, 2'd1, 2'd3, 8'h01), lat);
        exec(mk(4'd9, 2'd0, 2'd0, 2'd0, 8'h01), lat);
        chk_reg(2'd0, 8'hA5);
        exec(mk(4'd14, 2'd0, 2'd0, 2'd0, 8'h33), lat); chk("ill_lat", lat, 2);
        chk_reg(2'd0, 8'hA5);
        chk("no_err", {31'd0, err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
